count12_monitor: RTL and testbench
==================================

COUNT12_MONITOR -- requirements
Module: count12_monitor

Interface
REQ-001 Parameter LOCK_THRESH, default 3: consecutive matching samples required to enter LOCK; legal range 1..7.
REQ-002 Parameter ERR_W, default 8: width of err_count.
REQ-003 Parameter WRAP_W, default 16: width of wrap_count.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 valid_count  input  1  enable that drove the observed mod-12 counter in the same cycle.
REQ-007 cnt_in  input  4  observed counter value, legal 0..11.
REQ-008 clr  input  1  synchronous clear of err_count, wrap_count and sticky_err; FSM state unaffected.
REQ-009 locked  output  1  registered; high while FSM is in LOCK.
REQ-010 wrap_pulse  output  1  registered one-cycle pulse on a validated 11->0 step while in LOCK.
REQ-011 err_pulse  output  1  registered one-cycle pulse on loss of lock.
REQ-012 range_err  output  1  registered one-cycle pulse when cnt_in is 12..15 in any state.
REQ-013 sticky_err  output  1  set by err_pulse or range_err condition; cleared only by clr or reset.
REQ-014 err_count  output  ERR_W  number of lock losses, saturating at all-ones.
REQ-015 wrap_count  output  WRAP_W  number of wrap_pulse events, wraps modulo 2^WRAP_W.

Function
REQ-016 Block SHALL register prev_cnt and prev_en (cnt_in, valid_count) every cycle except while cnt_in is out of range.
REQ-017 expected SHALL be prev_cnt when prev_en=0, (prev_cnt==11 ? 0 : prev_cnt+1) when prev_en=1.
REQ-018 match SHALL be (cnt_in==expected) AND cnt_in<=11.
REQ-019 FSM states: IDLE, ACQ, LOCK.
REQ-020 IDLE: in-range cnt_in -> capture prev, acq_cnt=0, go ACQ; out-of-range -> stay IDLE, range_err.
REQ-021 ACQ: match -> acq_cnt+1; when acq_cnt+1 == LOCK_THRESH go LOCK. Mismatch -> acq_cnt=0, stay ACQ, no err_pulse.
REQ-022 LOCK: match -> stay; match with prev_en=1 and prev_cnt=11 -> wrap_pulse and wrap_count+1.
REQ-023 LOCK: mismatch -> err_pulse, err_count+1 (saturating), sticky_err=1, acq_cnt=0, go ACQ.
REQ-024 Out-of-range cnt_in in ACQ or LOCK SHALL count as mismatch (REQ-021/023) and also pulse range_err; prev not updated.
REQ-025 All outputs SHALL reflect the sample taken at edge N on the cycle after edge N (one-cycle latency).
REQ-026 clr coincident with an increment event: clear wins, counter reads 0; sticky_err reads 0; pulses unaffected.
REQ-027 Paused counter (valid_count=0) holding a constant value SHALL count as matching samples.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, acq_cnt=0, prev_cnt=0, prev_en=0 and every output to 0, including mid-acquisition or mid-lock.
REQ-029 First rising edge after rst_n release SHALL be treated as an IDLE sample.

Structure
REQ-030 Shared package count12_pkg SHALL hold CNT_MOD=12, CNT_MAX=4'd11, the FSM state enum, and a next_count(cnt,en) function used for REQ-017.
REQ-031 No sub-module is required; saturating err_count and wrapping wrap_count are inline.

Verification
REQ-032 Reset, then cnt_in 0,1,2,3 with valid_count=1 -> locked=1 the cycle after value 3, err_pulse=0.
REQ-033 Locked, cnt_in 10,11,0 with valid_count=1 -> one wrap_pulse after the 0 sample, wrap_count=1.
REQ-034 Locked at 5, cnt_in jumps to 7 -> err_pulse one cycle, err_count=1, sticky_err=1, locked=0; relocks after 3 further matches.
REQ-035 cnt_in=13 in LOCK -> range_err and err_pulse same cycle, locked=0; prev remains the last legal value.
REQ-036 err_count at 255, another lock loss -> stays 255; clr in same cycle -> 0.
REQ-037 rst_n asserted mid-LOCK -> locked=0 asynchronously, all counters 0, FSM re-enters IDLE.

Source files
------------

// File: rtl/count12_pkg.sv
// Shared definitions for the mod-12 counter monitor: counter limits, FSM
// state encoding and the expected-next-value function.
package count12_pkg;

  localparam int         CNT_MOD = 12;
  localparam logic [3:0] CNT_MAX = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // Value the observed counter should show next, given its last value and
  // whether it was enabled when that value was sampled.
  function automatic logic [3:0] next_count(input logic [3:0] cnt, input logic en);
    if (!en) return cnt;
    return (cnt == CNT_MAX) ? 4'd0 : cnt + 4'd1;
  endfunction

  function automatic logic cnt_in_range(input logic [3:0] cnt);
    return int'(cnt) < CNT_MOD;
  endfunction

endpackage

// File: rtl/count12_monitor.sv
// Watches an external mod-12 counter, locks onto it after LOCK_THRESH
// consecutive consistent samples, and reports wraps, lock losses and range errors.
module count12_monitor
  import count12_pkg::*;
#(
  parameter int LOCK_THRESH = 3,
  parameter int ERR_W       = 8,
  parameter int WRAP_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_count,
  input  logic [3:0]        cnt_in,
  input  logic              clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic              err_pulse,
  output logic              range_err,
  output logic              sticky_err,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  state_t     state_q, state_d;
  logic [2:0] acq_q, acq_d;
  logic [3:0] prev_cnt;
  logic       prev_en;

  logic       in_rng;
  logic       match;
  logic [3:0] acq_inc;
  logic       wrap_evt;
  logic       loss_evt;

  assign in_rng  = cnt_in_range(cnt_in);
  assign match   = in_rng && (cnt_in == next_count(prev_cnt, prev_en));
  assign acq_inc = {1'b0, acq_q} + 4'd1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    acq_d    = acq_q;
    wrap_evt = 1'b0;
    loss_evt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_rng) begin
          state_d = ST_ACQ;
          acq_d   = 3'd0;
        end
      end
      ST_ACQ: begin
        if (match) begin
          if (acq_inc == 4'(LOCK_THRESH)) begin
            state_d = ST_LOCK;
            acq_d   = 3'd0;
          end else begin
            acq_d = acq_inc[2:0];
          end
        end else begin
          acq_d = 3'd0;
        end
      end
      ST_LOCK: begin
        if (match) begin
          wrap_evt = prev_en && (prev_cnt == CNT_MAX);
        end else begin
          loss_evt = 1'b1;
          acq_d    = 3'd0;
          state_d  = ST_ACQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acq_d   = 3'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acq_q    <= 3'd0;
      prev_cnt <= 4'd0;
      prev_en  <= 1'b0;
    end else begin
      state_q <= state_d;
      acq_q   <= acq_d;
      // An illegal sample must not disturb the reference used for the next match.
      if (in_rng) begin
        prev_cnt <= cnt_in;
        prev_en  <= valid_count;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      range_err  <= 1'b0;
      sticky_err <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      locked     <= (state_d == ST_LOCK);
      wrap_pulse <= wrap_evt;
      err_pulse  <= loss_evt;
      range_err  <= !in_rng;
      // Clear takes priority over any coincident increment or sticky set.
      if (clr) begin
        sticky_err <= 1'b0;
        err_count  <= '0;
        wrap_count <= '0;
      end else begin
        if (loss_evt || !in_rng) sticky_err <= 1'b1;
        if (loss_evt && (err_count != '1)) err_count <= err_count + ERR_W'(1);
        if (wrap_evt) wrap_count <= wrap_count + WRAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count12_monitor.sv
// Directed bench for count12_monitor: a vector table for the main lock / wrap /
// loss / range / clear behaviour, plus hand sequences for saturation and reset.
module tb_count12_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_count;
  logic [3:0]  cnt_in;
  logic        clr;
  logic        locked, wrap_pulse, err_pulse, range_err, sticky_err;
  logic [7:0]  err_count;
  logic [15:0] wrap_count;

  int checks   = 0;
  int failures = 0;

  count12_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_count(valid_count),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .range_err  (range_err),
    .sticky_err (sticky_err),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       cl;
    logic       lk, wp, ep, re, st;
    int         ec, wc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [3:0] c, input logic cl,
                              input logic lk, input logic wp, input logic ep,
                              input logic re, input logic st, input int ec, input int wc);
    vec_t r;
    r.v = v; r.c = c; r.cl = cl;
    r.lk = lk; r.wp = wp; r.ep = ep; r.re = re; r.st = st;
    r.ec = ec; r.wc = wc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] c, input logic cl);
    @(negedge clk);
    valid_count = v;
    cnt_in      = c;
    clr         = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, " locked"},     32'(locked),     32'(e.lk));
    check({tag, " wrap_pulse"}, 32'(wrap_pulse), 32'(e.wp));
    check({tag, " err_pulse"},  32'(err_pulse),  32'(e.ep));
    check({tag, " range_err"},  32'(range_err),  32'(e.re));
    check({tag, " sticky_err"}, 32'(sticky_err), 32'(e.st));
    check({tag, " err_count"},  32'(err_count),  32'(e.ec));
    check({tag, " wrap_count"}, 32'(wrap_count), 32'(e.wc));
  endtask

  initial begin
    logic [3:0] val;
    rst_n = 1'b0; valid_count = 1'b0; cnt_in = 4'd0; clr = 1'b0;

    //           v  c    clr lk wp ep re st ec wc
    vecs.push_back(mk(1, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd1,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd2,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd3,  0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 4; k <= 11; k++)
      vecs.push_back(mk(1, 4'(k), 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd0,  0, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4'd1,  0, 1, 0, 0, 0, 0, 0, 1));
    for (int k = 2; k <= 5; k++)
      vecs.push_back(mk(1, 4'(k), 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4'd7,  0, 0, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(1, 4'd8,  0, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 4'd9,  0, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 4'd10, 0, 1, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 4'd13, 0, 0, 0, 1, 1, 1, 2, 1));
    vecs.push_back(mk(1, 4'd11, 0, 0, 0, 0, 0, 1, 2, 1));
    vecs.push_back(mk(1, 4'd0,  0, 0, 0, 0, 0, 1, 2, 1));
    vecs.push_back(mk(1, 4'd1,  0, 1, 0, 0, 0, 1, 2, 1));
    vecs.push_back(mk(0, 4'd2,  0, 1, 0, 0, 0, 1, 2, 1));
    vecs.push_back(mk(0, 4'd2,  0, 1, 0, 0, 0, 1, 2, 1));
    vecs.push_back(mk(1, 4'd2,  0, 1, 0, 0, 0, 1, 2, 1));
    vecs.push_back(mk(1, 4'd3,  0, 1, 0, 0, 0, 1, 2, 1));
    vecs.push_back(mk(1, 4'd7,  1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd8,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd9,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd10, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd11, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd0,  1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd1,  0, 1, 0, 0, 0, 0, 0, 0));

    repeat (2) @(negedge clk);
    check_all("reset", mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].c, vecs[i].cl);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Saturation: 255 loss/relock rounds using a paused counter, alternating 3 and 7.
    for (int i = 0; i < 255; i++) begin
      val = (i % 2) ? 4'd7 : 4'd3;
      repeat (4) step(1'b0, val, 1'b0);
    end
    check("sat locked", 32'(locked), 32'd1);
    check("sat err_count 255", 32'(err_count), 32'd255);
    check("sat sticky", 32'(sticky_err), 32'd1);
    step(1'b0, 4'd7, 1'b0);
    check("sat hold err_pulse", 32'(err_pulse), 32'd1);
    check("sat hold err_count", 32'(err_count), 32'd255);
    repeat (3) step(1'b0, 4'd7, 1'b0);
    check("sat relock", 32'(locked), 32'd1);
    step(1'b0, 4'd3, 1'b1);
    check("sat clr err_pulse", 32'(err_pulse), 32'd1);
    check("sat clr err_count", 32'(err_count), 32'd0);
    check("sat clr sticky", 32'(sticky_err), 32'd0);
    repeat (3) step(1'b0, 4'd3, 1'b0);
    step(1'b0, 4'd7, 1'b0);
    check("loss after clr err_count", 32'(err_count), 32'd1);
    repeat (3) step(1'b0, 4'd7, 1'b0);
    step(1'b1, 4'd7, 1'b0);
    for (int k = 8; k <= 11; k++) step(1'b1, 4'(k), 1'b0);
    step(1'b1, 4'd0, 1'b0);
    check("pre-reset wrap_count", 32'(wrap_count), 32'd1);
    check("pre-reset locked", 32'(locked), 32'd1);

    // Asynchronous reset in the middle of a cycle while locked.
    #2 rst_n = 1'b0;
    #1;
    check_all("async reset", mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First sample after reset is an IDLE sample: out of range stays in IDLE.
    step(1'b1, 4'd14, 1'b0);
    check("idle range_err", 32'(range_err), 32'd1);
    check("idle sticky", 32'(sticky_err), 32'd1);
    check("idle err_pulse", 32'(err_pulse), 32'd0);
    step(1'b1, 4'd0, 1'b0);
    check("idle range_err clears", 32'(range_err), 32'd0);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    check("relock not yet", 32'(locked), 32'd0);
    step(1'b1, 4'd3, 1'b0);
    check("relock after reset", 32'(locked), 32'd1);
    check("err_count after reset", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
